// File: rtl/ntt_host_loader.sv
// ntt_host_loader
// Host-side sequencer for the NTT/INTT wrapper. It packs the host coefficient
// stream into pairs and writes them into the wrapper input RAM, pulses start,
// captures the result pairs shown while core_cal_done is high into a FIFO, and
// replays them to the host as a valid/ready stream (dout1 before dout2).
//
// Optional build macro: NTT_HOST_LOADER_PERF_EN adds perf_cycles, a saturating
// count of cycles from core_start up to the cycle core_done is first seen.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   go, mode_in                      transform request (IDLE only), 0=NTT 1=INTT
//   s_valid/s_ready/s_data           coefficient input stream, index 0 first
//   m_valid/m_ready/m_data           result output stream
//   core_we, core_addr_a/b,
//   core_data_a/b, core_start,
//   core_mode                        wrapper load/control side
//   core_cal_done, core_done,
//   core_dout1/2                     wrapper result side
//   busy                             high outside IDLE
//   err                              sticky error, cleared on accepted go
module ntt_host_loader #(
    parameter int N          = 256,
    parameter int DW         = 16,
    parameter int AW         = 8,
    parameter int FIFO_DEPTH = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          mode_in,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          core_we,
    output logic [AW-1:0] core_addr_a,
    output logic [AW-1:0] core_addr_b,
    output logic [DW-1:0] core_data_a,
    output logic [DW-1:0] core_data_b,
    output logic          core_start,
    output logic          core_mode,
    input  logic          core_cal_done,
    input  logic          core_done,
    input  logic [DW-1:0] core_dout1,
    input  logic [DW-1:0] core_dout2,
`ifdef NTT_HOST_LOADER_PERF_EN
    output logic [15:0]   perf_cycles,
`endif
    output logic          busy,
    output logic          err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_PAIR = AW'(N / 2 - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_CAL, CAPTURE, DRAIN} state_t;
    state_t state_reg, state_next;

    logic          mode_reg, err_reg, done_seen_reg, load_done_reg, phase_reg;
    logic [DW-1:0] hold_reg;
    logic [AW-1:0] pair_idx_reg, cap_cnt_reg;
    logic          we_reg;
    logic [AW-1:0] addr_a_reg, addr_b_reg;
    logic [DW-1:0] data_a_reg, data_b_reg;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          half_reg;      // 0: dout1 of head pair is presented, 1: dout2
    logic [2*DW-1:0] fifo_mem [FIFO_DEPTH];

    logic go_acc, s_hs, cap_active, fifo_full, m_hs, push, pop, overflow, last_cap;
    logic [2*DW-1:0] rd_word;

    assign go_acc     = (state_reg == IDLE) && go;
    assign s_ready    = (state_reg == LOAD) && !load_done_reg;
    assign s_hs       = s_valid && s_ready;
    // The first cal_done cycle is seen in WAIT_CAL, so capture runs there too.
    assign cap_active = ((state_reg == WAIT_CAL) || (state_reg == CAPTURE)) && core_cal_done;
    assign last_cap   = (cap_cnt_reg == LAST_PAIR);
    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign m_valid    = ((state_reg == CAPTURE) || (state_reg == DRAIN)) && (count_reg != '0);
    assign m_hs       = m_valid && m_ready;
    assign pop        = m_hs && half_reg;
    // A full FIFO still accepts a push when the head pair leaves in the same cycle.
    assign push       = cap_active && (!fifo_full || pop);
    assign overflow   = cap_active && fifo_full && !pop;
    assign rd_word    = fifo_mem[rd_ptr_reg];
    assign m_data     = !m_valid ? '0 : (half_reg ? rd_word[DW-1:0] : rd_word[2*DW-1:DW]);

    assign busy        = (state_reg != IDLE);
    assign err         = err_reg;
    assign core_mode   = mode_reg;
    assign core_we     = we_reg;
    assign core_addr_a = addr_a_reg;
    assign core_addr_b = addr_b_reg;
    assign core_data_a = data_a_reg;
    assign core_data_b = data_b_reg;
    assign core_start  = (state_reg == START);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (go) state_next = LOAD;
            // load_done_reg is set while the final core_we is being driven,
            // so START follows that pulse by exactly one cycle.
            LOAD:     if (load_done_reg) state_next = START;
            START:    state_next = WAIT_CAL;
            WAIT_CAL: begin
                if (core_cal_done)  state_next = last_cap ? DRAIN : CAPTURE;
                else if (core_done) state_next = IDLE;
            end
            CAPTURE:  if (!core_cal_done || last_cap) state_next = DRAIN;
            DRAIN:    if ((count_reg == '0) && (done_seen_reg || core_done)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_reg      <= 1'b0;
            err_reg       <= 1'b0;
            done_seen_reg <= 1'b0;
            load_done_reg <= 1'b0;
            phase_reg     <= 1'b0;
            hold_reg      <= '0;
            pair_idx_reg  <= '0;
            cap_cnt_reg   <= '0;
            we_reg        <= 1'b0;
            addr_a_reg    <= '0;
            addr_b_reg    <= '0;
            data_a_reg    <= '0;
            data_b_reg    <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            half_reg      <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            if (go_acc) begin
                mode_reg      <= mode_in;
                err_reg       <= 1'b0;
                done_seen_reg <= 1'b0;
                load_done_reg <= 1'b0;
                phase_reg     <= 1'b0;
                pair_idx_reg  <= '0;
                cap_cnt_reg   <= '0;
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                count_reg     <= '0;
                half_reg      <= 1'b0;
            end else begin
                if (s_hs) begin
                    if (!phase_reg) begin
                        hold_reg  <= s_data;
                        phase_reg <= 1'b1;
                    end else begin
                        we_reg       <= 1'b1;
                        addr_a_reg   <= {pair_idx_reg[AW-2:0], 1'b0};
                        addr_b_reg   <= {pair_idx_reg[AW-2:0], 1'b1};
                        data_a_reg   <= hold_reg;
                        data_b_reg   <= s_data;
                        phase_reg    <= 1'b0;
                        pair_idx_reg <= pair_idx_reg + 1'b1;
                        if (pair_idx_reg == LAST_PAIR) load_done_reg <= 1'b1;
                    end
                end
                // Dropped pushes still count, so a full FIFO cannot stall capture.
                if (cap_active) cap_cnt_reg <= cap_cnt_reg + 1'b1;
                if (core_done && (state_reg != IDLE)) done_seen_reg <= 1'b1;
                if (overflow ||
                    ((state_reg == WAIT_CAL) && !core_cal_done && core_done) ||
                    ((state_reg == CAPTURE) && !core_cal_done))
                    err_reg <= 1'b1;
                if (push) wr_ptr_reg <= (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
                if (pop)  rd_ptr_reg <= (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
                if (m_hs) half_reg <= ~half_reg;
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= {core_dout1, core_dout2};
    end

`ifdef NTT_HOST_LOADER_PERF_EN
    logic [15:0] perf_reg;
    logic        perf_run_reg;

    assign perf_cycles = perf_reg;

    // Counts the START cycle and every following cycle until core_done shows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_reg     <= '0;
            perf_run_reg <= 1'b0;
        end else if (go_acc) begin
            perf_reg     <= '0;
            perf_run_reg <= 1'b0;
        end else begin
            if ((state_reg == START) || (perf_run_reg && !core_done)) begin
                if (perf_reg != 16'hFFFF) perf_reg <= perf_reg + 16'd1;
            end
            if (state_reg == START) perf_run_reg <= 1'b1;
            else if (core_done)     perf_run_reg <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ntt_host_loader.sv
// Scoreboard bench for ntt_host_loader: stimulus pushes expected RAM writes and
// expected result beats into queues; negedge monitors pop and compare.
module tb_ntt_host_loader;
    localparam int N  = 256;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int FD = 128;

    logic          clk, rst, go, mode_in, s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data, core_data_a, core_data_b, core_dout1, core_dout2;
    logic [AW-1:0] core_addr_a, core_addr_b;
    logic          core_we, core_start, core_mode, core_cal_done, core_done, busy, err;
`ifdef NTT_HOST_LOADER_PERF_EN
    logic [15:0]   perf_cycles;
`endif

    ntt_host_loader #(.N(N), .DW(DW), .AW(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .go(go), .mode_in(mode_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .core_we(core_we), .core_addr_a(core_addr_a), .core_addr_b(core_addr_b),
        .core_data_a(core_data_a), .core_data_b(core_data_b),
        .core_start(core_start), .core_mode(core_mode),
        .core_cal_done(core_cal_done), .core_done(core_done),
        .core_dout1(core_dout1), .core_dout2(core_dout2),
`ifdef NTT_HOST_LOADER_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .busy(busy), .err(err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_count, start_count, beats, last_we_cyc, ready_pat;
    logic exp_mode;
    logic [DW-1:0]         exp_beats [$];
    logic [2*AW+2*DW-1:0]  exp_we [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output ready pattern: 0 = always ready, 1 = ready one cycle in three.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (ready_pat == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    // Monitors: RAM writes, start pulse, output beats.
    always @(negedge clk) begin
        if (rst) begin
            if (core_we) begin
                we_count++;
                last_we_cyc = cyc;
                if (exp_we.size() == 0) check("we_unexpected", {core_addr_a, core_addr_b, core_data_a, core_data_b}, 64'hFFFF_FFFF_FFFF_FFFF);
                else check("we_pair", {core_addr_a, core_addr_b, core_data_a, core_data_b}, exp_we.pop_front());
            end
            if (core_start) begin
                start_count++;
                check("start_after_last_we", 64'(cyc), 64'(last_we_cyc + 1));
                check("core_mode_at_start", core_mode, exp_mode);
            end
            if (m_valid && m_ready) begin
                beats++;
                if (exp_beats.size() == 0) check("beat_unexpected", m_data, 64'hFFFF_FFFF);
                else check("beat", m_data, exp_beats.pop_front());
                $display("beat %0d data=%0h", beats, m_data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_core_we"}, core_we, 0);
        check({tag, "_addr_a"}, core_addr_a, 0);
        check({tag, "_addr_b"}, core_addr_b, 0);
        check({tag, "_data_a"}, core_data_a, 0);
        check({tag, "_data_b"}, core_data_b, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_core_mode"}, core_mode, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
`ifdef NTT_HOST_LOADER_PERF_EN
        check({tag, "_perf"}, perf_cycles, 0);
`endif
    endtask

    task automatic send(input logic [DW-1:0] v);
        logic ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = v;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        if (!ok) check("s_ready_timeout", 0, 1);
    endtask

    task automatic load_coefs(input int n, input logic [DW-1:0] base);
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 1) begin
                a0 = AW'(i - 1);
                a1 = AW'(i);
                d0 = base + DW'(i - 1);
                d1 = base + DW'(i);
                exp_we.push_back({a0, a1, d0, d1});
            end
            send(base + DW'(i));
        end
    endtask

    // Wrapper model: cal_done for win cycles after start, core_done at start+done_at.
    task automatic run_core(input int win, input int done_at);
        logic ok;
        logic [DW-1:0] v1, v2;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (core_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("start_timeout", 0, 1);
        for (int c = 1; c <= done_at; c++) begin
            @(posedge clk);
            #1;
            core_cal_done = (c <= win);
            if (c <= win) begin
                v1 = DW'(2 * (c - 1));
                v2 = DW'(2 * (c - 1) + 1);
                core_dout1 = v1;
                core_dout2 = v2;
                exp_beats.push_back(v1);
                exp_beats.push_back(v2);
            end
            core_done = (c == done_at);
        end
        @(posedge clk);
        #1;
        core_cal_done = 1'b0;
        core_done     = 1'b0;
    endtask

    task automatic do_run(input logic md, input logic [DW-1:0] base, input int win,
                          input int done_at, input int rpat, input logic exp_err);
        logic ok;
        ready_pat   = rpat;
        exp_mode    = md;
        we_count    = 0;
        start_count = 0;
        beats       = 0;
        @(posedge clk);
        #1;
        go = 1'b1;
        mode_in = md;
        @(posedge clk);
        #1;
        go = 1'b0;
        load_coefs(N, base);
        run_core(win, done_at);
        ok = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", ok, 1);
        check("err", err, exp_err);
        check("beat_count", beats, 2 * win);
        check("beats_left", exp_beats.size(), 0);
        check("we_left", exp_we.size(), 0);
        check("we_count", we_count, N / 2);
        check("start_count", start_count, 1);
        check("core_mode_hold", core_mode, md);
`ifdef NTT_HOST_LOADER_PERF_EN
        check("perf_cycles", perf_cycles, done_at);
`endif
        $display("run mode=%0d win=%0d done_at=%0d ready_pat=%0d beats=%0d err=%0d",
                 md, win, done_at, rpat, beats, err);
    endtask

    initial begin
        rst = 1'b0;
        go = 1'b0;
        mode_in = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        core_cal_done = 1'b0;
        core_done = 1'b0;
        core_dout1 = '0;
        core_dout2 = '0;
        ready_pat = 0;
        exp_mode = 1'b0;
        last_we_cyc = 0;
        we_count = 0;
        start_count = 0;
        beats = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;

        // Basic NTT load + result capture, m_ready held high.
        do_run(1'b0, 16'h0000, N / 2, 140, 0, 1'b0);
        // Backpressure: m_ready one cycle in three.
        do_run(1'b1, 16'h1000, N / 2, 140, 1, 1'b0);
        // Short cal_done window: 100 pairs only.
        do_run(1'b0, 16'h2000, 100, 140, 0, 1'b1);

        // Reset mid-LOAD after 37 coefficients.
        @(posedge clk);
        #1;
        exp_mode = 1'b1;
        go = 1'b1;
        mode_in = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        load_coefs(37, 16'h3000);
        rst = 1'b0;
        #1;
        check_reset_outputs("midload");
        check("midload_we_left", exp_we.size(), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_run(1'b1, 16'h0000, N / 2, 140, 0, 1'b0);

        // Long transform: core_done 500 cycles after start.
        do_run(1'b0, 16'h4000, N / 2, 500, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
